apb_master: RTL and testbench
=============================

# apb_master

APB initiator that turns single-word CPU-side requests into APB3 transfers to the peripheral slaves (FND, GPIO, UART, …) on the PCLK domain. It decodes the request address into one of `N_SLV` slave windows and drives the shared `PADDR`/`PWRITE`/`PWDATA`/`PENABLE` lines plus a one-hot `PSEL`. It waits on the selected slave's `PREADY` and returns read data, completion and error status to the requester. It sits between the core's bus port and every APB peripheral.

## Interface
Parameters:
- `N_SLV`, 4, number of slave windows (1..8)
- `BASE_ADDR`, 32'h1000_0000, start of the APB region
- `SLV_SHIFT`, 12, log2 of the window size (4 KB per slave)
- `TIMEOUT`, 256, maximum number of ACCESS cycles before abort (≥2)

Ports:
- `PCLK` in 1: the block's single clock
- `PRESET` in 1: reset, synchronous, active-high
- `i_req` in 1: request strobe; sampled only in IDLE
- `i_write` in 1: 1 = write, 0 = read
- `i_addr` in 32: byte address
- `i_wdata` in 32: write data
- `o_ready` out 1: one-cycle completion pulse
- `o_err` out 1: error flag, valid with `o_ready`
- `o_rdata` out 32: read data, valid with `o_ready`
- `o_busy` out 1: high whenever the state is not IDLE
- `PADDR` out 32, `PWRITE` out 1, `PWDATA` out 32, `PENABLE` out 1: shared APB lines
- `PSEL` out N_SLV: one-hot slave select
- `PRDATA` in N_SLV*32: slave i occupies bits [32i+31:32i]
- `PREADY` in N_SLV: per-slave ready

## Operation
- **Outputs:** all outputs are registered. Reset value of every output is 0.
- **States:** IDLE, SETUP, ACCESS.
- **IDLE:**
  - If `i_req`=1, latch `i_addr`/`i_wdata`/`i_write`.
  - Decode: `off = i_addr - BASE_ADDR`; `idx = off >> SLV_SHIFT`. The address is valid iff `i_addr >= BASE_ADDR` and `idx < N_SLV`.
  - If valid: go to SETUP and drive `PSEL[idx]`=1, `PENABLE`=0, `PADDR`=`i_addr` (full address), `PWRITE`, `PWDATA`.
  - If invalid: stay in IDLE, no APB activity. Next cycle `o_ready`=1, `o_err`=1, `o_rdata`=0.
- **SETUP:** exactly one cycle. Then go to ACCESS with `PENABLE`=1; `PSEL`, `PADDR`, `PWRITE`, `PWDATA` are held.
- **ACCESS:** sample `PREADY[idx]` every cycle; other slaves' `PREADY` are ignored.
  - On `PREADY[idx]`=1: go to IDLE and clear `PSEL`/`PENABLE`. Next cycle `o_ready`=1, `o_err`=0, and `o_rdata` = `PRDATA` slice `idx` for reads or 0 for writes.
- **Timeout:**
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle with `PREADY[idx]`=0.
  - When the counter equals `TIMEOUT-1` and `PREADY[idx]`=0: go to IDLE, clear `PSEL`/`PENABLE`, then pulse `o_ready` with `o_err`=1 and `o_rdata`=0.
  - Counter width is `$clog2(TIMEOUT)`; it never wraps.
- **Requests while busy:** `i_req` is ignored in SETUP and ACCESS. There is no queueing.
- **Output hold:** `o_rdata` and `o_err` hold their last values until the next completion. `o_ready` is high for exactly one cycle per accepted request.
- **APB line hold:** `PADDR`, `PWRITE` and `PWDATA` keep their last values in IDLE. Only `PSEL`/`PENABLE` return to 0.
- **Reset mid-transfer:** on the next edge the block is in IDLE and all outputs are 0. No `o_ready` is issued for the aborted transfer.

## Timing
- Request accepted at edge k; SETUP is cycle k+1; ACCESS starts at cycle k+2.
- With a zero-wait slave (`PREADY` high in k+2), `o_ready` is high in cycle k+3.
- With a registered-ready slave (`PREADY` high in k+3), `o_ready` is high in cycle k+4.
- General case: `o_ready` = 3 cycles + ACCESS wait cycles after acceptance. A decode error gives `o_ready` at k+1.
- Back-to-back requests: a request is accepted in the same cycle `o_ready` is high, since the state is already IDLE. `PSEL` is therefore low for at least one cycle between transfers.
- `PREADY` is never sampled outside ACCESS. A stale `PREADY` that a registered slave leaves high in the IDLE cycle is therefore harmless.

## Test plan
- **Registered-ready write:**
  - Stimulus: `N_SLV`=4. Write `i_addr`=0x1000_1004, `i_wdata`=1234; slave 1 raises `PREADY` one cycle into ACCESS.
  - Required: `PSEL`=4'b0010 for k+1..k+3, `PENABLE` high in k+2..k+3, `PADDR`=0x1000_1004, `PWDATA`=1234; `o_ready` in k+4 with `o_err`=0.
- **Zero-wait read:**
  - Stimulus: read 0x1000_3014; slave 3 drives `PRDATA`=0x3132_3334 with `PREADY` tied high.
  - Required: `o_ready` in k+3 with `o_rdata`=0x3132_3334.
- **Decode error:**
  - Stimulus: reads of 0x0FFF_FFFC and 0x1000_4000.
  - Required: `PSEL` stays 0; `o_ready` at k+1 with `o_err`=1 and `o_rdata`=0.
- **Timeout:**
  - Stimulus: `TIMEOUT`=8, slave 2 never raises `PREADY`.
  - Required: `PENABLE` high for exactly 8 cycles; then `o_ready`=1, `o_err`=1; `o_busy` low afterwards.
- **Back-to-back and busy:**
  - Stimulus: assert `i_req` in the `o_ready` cycle; also pulse `i_req` during ACCESS.
  - Required: the first request is accepted and its SETUP follows immediately; the pulse during ACCESS produces no extra transfer or `o_ready`.
- **Reset mid-ACCESS:**
  - Stimulus: assert `PRESET` for one cycle during ACCESS.
  - Required: next cycle all outputs are 0 and the state is IDLE; no `o_ready` for the aborted transfer; a subsequent read completes normally.

Source files
------------

// File: rtl/apb_master.sv
`timescale 1ns/1ps
// APB3 initiator: decodes a single-word request into one of N_SLV slave windows,
// runs the SETUP/ACCESS handshake and reports completion, read data and errors.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for i_req; decode errors complete here directly
// ST_SETUP  | PSEL asserted, PENABLE low, one cycle only
// ST_ACCESS | PENABLE high, waiting on the selected PREADY or the wait timer
module apb_master #(
   parameter int          N_SLV     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
   parameter int          SLV_SHIFT = 12,
   parameter int          TIMEOUT   = 256
) (
   input  logic                PCLK,
   input  logic                PRESET,
   input  logic                i_req,
   input  logic                i_write,
   input  logic [31:0]         i_addr,
   input  logic [31:0]         i_wdata,
   output logic                o_ready,
   output logic                o_err,
   output logic [31:0]         o_rdata,
   output logic                o_busy,
   output logic [31:0]         PADDR,
   output logic                PWRITE,
   output logic [31:0]         PWDATA,
   output logic                PENABLE,
   output logic [N_SLV-1:0]    PSEL,
   input  logic [N_SLV*32-1:0] PRDATA,
   input  logic [N_SLV-1:0]    PREADY
);

   localparam int IDXW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
   localparam int CW   = $clog2(TIMEOUT);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

   state_t          r_state;
   logic [IDXW-1:0] r_idx;
   logic [CW-1:0]   r_cnt;

   logic [31:0]     w_off;
   logic [31:0]     w_slot;
   logic            w_valid;
   logic [IDXW-1:0] w_idx;
   logic            w_pready;
   logic [31:0]     w_prdata;
   logic [31:0]     w_prdata_arr [N_SLV];

   for (genvar g = 0; g < N_SLV; g++) begin : g_prdata
      assign w_prdata_arr[g] = PRDATA[32*g +: 32];
   end

   assign w_off    = i_addr - BASE_ADDR;
   assign w_slot   = w_off >> SLV_SHIFT;
   assign w_valid  = (i_addr >= BASE_ADDR) && (w_slot < 32'(N_SLV));
   assign w_idx    = w_slot[IDXW-1:0];
   assign w_pready = PREADY[r_idx];
   assign w_prdata = w_prdata_arr[r_idx];

   // Wait timer runs down from TIMEOUT-1; reaching zero without PREADY aborts.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         o_ready <= 1'b0;
         o_err   <= 1'b0;
         o_rdata <= '0;
         o_busy  <= 1'b0;
         PADDR   <= '0;
         PWRITE  <= 1'b0;
         PWDATA  <= '0;
         PENABLE <= 1'b0;
         PSEL    <= '0;
      end else begin
         o_ready <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_req) begin
                  if (w_valid) begin
                     r_state <= ST_SETUP;
                     r_idx   <= w_idx;
                     o_busy  <= 1'b1;
                     PSEL    <= N_SLV'(1) << w_idx;
                     PENABLE <= 1'b0;
                     PADDR   <= i_addr;
                     PWRITE  <= i_write;
                     PWDATA  <= i_wdata;
                  end else begin
                     o_ready <= 1'b1;
                     o_err   <= 1'b1;
                     o_rdata <= '0;
                  end
               end
            end
            ST_SETUP: begin
               r_state <= ST_ACCESS;
               r_cnt   <= CW'(TIMEOUT - 1);
               PENABLE <= 1'b1;
            end
            ST_ACCESS: begin
               if (w_pready) begin
                  r_state <= ST_IDLE;
                  o_busy  <= 1'b0;
                  PSEL    <= '0;
                  PENABLE <= 1'b0;
                  o_ready <= 1'b1;
                  o_err   <= 1'b0;
                  o_rdata <= PWRITE ? 32'h0 : w_prdata;
               end else if (r_cnt == '0) begin
                  r_state <= ST_IDLE;
                  o_busy  <= 1'b0;
                  PSEL    <= '0;
                  PENABLE <= 1'b0;
                  o_ready <= 1'b1;
                  o_err   <= 1'b1;
                  o_rdata <= '0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
`timescale 1ns/1ps
// Directed bench for apb_master: cycle-exact APB line checks plus a completion
// scoreboard that expects exactly one o_ready per accepted request.
module tb_apb_master;

   localparam int N_SLV = 4;

   logic                PCLK = 1'b0;
   logic                PRESET;
   logic                i_req;
   logic                i_write;
   logic [31:0]         i_addr;
   logic [31:0]         i_wdata;
   logic                o_ready;
   logic                o_err;
   logic [31:0]         o_rdata;
   logic                o_busy;
   logic [31:0]         PADDR;
   logic                PWRITE;
   logic [31:0]         PWDATA;
   logic                PENABLE;
   logic [N_SLV-1:0]    PSEL;
   logic [N_SLV*32-1:0] PRDATA;
   logic [N_SLV-1:0]    PREADY;

   int n_total = 0;
   int n_pass  = 0;
   logic [32:0] sb[$];

   apb_master #(
      .N_SLV(N_SLV), .BASE_ADDR(32'h1000_0000), .SLV_SHIFT(12), .TIMEOUT(8)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .i_req(i_req), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
      .o_ready(o_ready), .o_err(o_err), .o_rdata(o_rdata), .o_busy(o_busy),
      .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE),
      .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   // Returns one cycle after the acceptance edge (i.e. in cycle k+1).
   task automatic drive_req(input logic wr, input logic [31:0] a, input logic [31:0] d);
      i_req   = 1'b1;
      i_write = wr;
      i_addr  = a;
      i_wdata = d;
      step();
      i_req = 1'b0;
   endtask

   // Completion monitor: every o_ready must match the oldest pending expectation.
   always @(negedge PCLK) begin
      if (o_ready === 1'b1) begin
         n_total++;
         assert (sb.size() > 0) n_pass++;
         else $error("FAIL unexpected_ready: observed o_ready=1 expected no pending completion");
         if (sb.size() > 0) chk("completion", {31'b0, o_err, o_rdata}, {31'b0, sb.pop_front()});
      end
   end

   initial begin
      int  en_cnt;
      bit  seen;

      PRESET  = 1'b1;
      i_req   = 1'b0;
      i_write = 1'b0;
      i_addr  = '0;
      i_wdata = '0;
      PRDATA  = '0;
      PREADY  = '0;
      step();
      step();
      chk("reset_ctrl", {PSEL, PENABLE, PWRITE, o_ready, o_err, o_busy}, 0);
      chk("reset_paddr", PADDR, 0);
      chk("reset_rdata", o_rdata, 0);
      PRESET = 1'b0;
      step();

      // Registered-ready write to slave 1, with a stray PREADY[0] and a busy i_req pulse.
      sb.push_back({1'b0, 32'h0});
      drive_req(1'b1, 32'h1000_1004, 32'd1234);
      chk("w_setup_psel", {PSEL, PENABLE, o_busy}, {4'b0010, 1'b0, 1'b1});
      chk("w_setup_paddr", PADDR, 32'h1000_1004);
      chk("w_setup_pwdata", {PWRITE, PWDATA}, {1'b1, 32'd1234});
      step();
      PREADY  = 4'b0001;
      i_req   = 1'b1;
      i_write = 1'b0;
      i_addr  = 32'h1000_3000;
      chk("w_access1", {PSEL, PENABLE, o_ready}, {4'b0010, 1'b1, 1'b0});
      step();
      i_req  = 1'b0;
      PREADY = 4'b0010;
      chk("w_access2", {PSEL, PENABLE, o_ready}, {4'b0010, 1'b1, 1'b0});
      chk("w_access2_paddr", PADDR, 32'h1000_1004);
      step();
      PREADY = 4'b0000;
      chk("w_done", {PSEL, PENABLE, o_ready, o_err, o_busy}, {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0});
      chk("w_hold_lines", {PWRITE, PADDR}, {1'b1, 32'h1000_1004});
      step();
      chk("w_no_extra", {PSEL, o_busy, o_ready}, 0);
      step();
      chk("w_no_extra2", {PSEL, o_busy, o_ready}, 0);

      // Zero-wait read from slave 3; PREADY[3] is left high through IDLE.
      PRDATA[3*32 +: 32] = 32'h3132_3334;
      PREADY = 4'b1000;
      sb.push_back({1'b0, 32'h3132_3334});
      drive_req(1'b0, 32'h1000_3014, 32'hFFFF_FFFF);
      chk("r_setup", {PSEL, PENABLE}, {4'b1000, 1'b0});
      step();
      chk("r_access", {PSEL, PENABLE, o_ready}, {4'b1000, 1'b1, 1'b0});
      step();
      chk("r_done", {o_ready, o_err, o_rdata}, {1'b1, 1'b0, 32'h3132_3334});
      step();
      chk("r_hold", {o_ready, o_rdata}, {1'b0, 32'h3132_3334});
      PREADY = 4'b0000;

      // Decode errors below the base and just past the last window.
      sb.push_back({1'b1, 32'h0});
      drive_req(1'b0, 32'h0FFF_FFFC, 32'h0);
      chk("dec_lo", {PSEL, PENABLE, o_busy, o_ready, o_err, o_rdata}, {4'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0});
      step();
      chk("dec_lo_after", {PSEL, o_ready, o_busy}, 0);
      sb.push_back({1'b1, 32'h0});
      drive_req(1'b0, 32'h1000_4000, 32'h0);
      chk("dec_hi", {PSEL, PENABLE, o_busy, o_ready, o_err, o_rdata}, {4'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0});
      step();

      // Timeout on slave 2 while every other slave reports ready.
      PREADY = 4'b1011;
      PRDATA[2*32 +: 32] = 32'h2222_2222;
      sb.push_back({1'b1, 32'h0});
      drive_req(1'b0, 32'h1000_2000, 32'h0);
      en_cnt = 0;
      seen   = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (o_ready === 1'b1) seen = 1'b1;
         else begin
            if (PENABLE === 1'b1) en_cnt++;
            step();
         end
      end
      chk("to_seen", {63'b0, seen}, 1);
      chk("to_penable_cycles", en_cnt, 8);
      chk("to_status", {o_err, o_busy, PSEL, PENABLE}, {1'b1, 1'b0, 4'b0, 1'b0});
      step();
      chk("to_idle", {o_busy, o_ready}, 0);
      PREADY = 4'b0000;

      // Back-to-back: second request raised in the o_ready cycle of the first.
      PREADY = 4'b0001;
      sb.push_back({1'b0, 32'h0});
      drive_req(1'b1, 32'h1000_0008, 32'h5555_AAAA);
      step();
      step();
      chk("b2b_first_done", {o_ready, PSEL}, {1'b1, 4'b0000});
      PRDATA[1*32 +: 32] = 32'hA5A5_0001;
      PREADY = 4'b0010;
      sb.push_back({1'b0, 32'hA5A5_0001});
      drive_req(1'b0, 32'h1000_1010, 32'h0);
      chk("b2b_second_setup", {PSEL, PENABLE, PWRITE, o_busy}, {4'b0010, 1'b0, 1'b0, 1'b1});
      chk("b2b_second_paddr", PADDR, 32'h1000_1010);
      step();
      step();
      chk("b2b_second_done", {o_ready, o_rdata}, {1'b1, 32'hA5A5_0001});
      step();
      PREADY = 4'b0000;

      // Reset during ACCESS: everything clears and no completion appears.
      drive_req(1'b0, 32'h1000_2004, 32'h0);
      step();
      chk("rst_mid_access", {PSEL, PENABLE}, {4'b0100, 1'b1});
      PRESET = 1'b1;
      step();
      PRESET = 1'b0;
      chk("rst_ctrl", {PSEL, PENABLE, PWRITE, o_ready, o_err, o_busy}, 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_pwdata", PWDATA, 0);
      chk("rst_rdata", o_rdata, 0);
      for (int i = 0; i < 4; i++) step();
      chk("rst_quiet", {o_ready, o_busy}, 0);
      PRDATA[2*32 +: 32] = 32'hDEAD_BEEF;
      PREADY = 4'b0100;
      sb.push_back({1'b0, 32'hDEAD_BEEF});
      drive_req(1'b0, 32'h1000_2004, 32'h0);
      step();
      step();
      chk("post_rst_read", {o_ready, o_err, o_rdata}, {1'b1, 1'b0, 32'hDEAD_BEEF});
      step();
      step();

      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
